issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 25 ++
 rtl/issue_scoreboard_pending_file.sv | 48 ++++
 rtl/issue_scoreboard.sv | 77 +++++++
 tb/tb_issue_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: default sizes, register-index
// width and the instruction field layout used by the decoder.
package issue_scoreboard_pkg;

  localparam int NUM_REGS_DEF     = 32;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int REG_IDX_W        = 5;
  localparam int INFLIGHT_W       = 3;
  localparam int STALL_W          = 32;

  // Instruction field positions (msb/lsb pairs)
  localparam int OPC_MSB = 4;
  localparam int OPC_LSB = 0;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 5;
  localparam int RS_MSB  = 14;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 19;
  localparam int RT_LSB  = 15;
  localparam int L_MSB   = 31;
  localparam int L_LSB   = 20;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/issue_scoreboard_pending_file.sv
// Per-register pending bits with set/clear and three bypassed lookups:
// a clear in the current cycle hides the bit from the lookups immediately.
module sb_pending_file
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t look_a,
  input  reg_idx_t look_b,
  input  reg_idx_t look_c,
  output logic     busy_a,
  output logic     busy_b,
  output logic     busy_c
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && (int'(set_idx) < NUM_REGS)) set_vec[set_idx] = 1'b1;
    if (clr_en && (int'(clr_idx) < NUM_REGS)) clr_vec[clr_idx] = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue of r keeps r pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_vec) | set_vec;
  end

  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    busy_c = 1'b0;
    if (int'(look_a) < NUM_REGS) busy_a = pending[look_a] && !(clr_en && clr_idx == look_a);
    if (int'(look_b) < NUM_REGS) busy_b = pending[look_b] && !(clr_en && clr_idx == look_b);
    if (int'(look_c) < NUM_REGS) busy_c = pending[look_c] && !(clr_en && clr_idx == look_c);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: blocks RAW/WAW hazards on pending destination
// registers and limits the number of uncommitted instructions.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [REG_IDX_W-1:0]  iss_rd,
  input  logic [REG_IDX_W-1:0]  iss_rs,
  input  logic [REG_IDX_W-1:0]  iss_rt,
  input  logic                  iss_rd_we,
  input  logic                  iss_rs_used,
  input  logic                  iss_rt_used,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic [STALL_W-1:0]    stall_cnt,
  output logic                  sb_error
);

  localparam logic [INFLIGHT_W-1:0] MAX_CNT = INFLIGHT_W'(MAX_INFLIGHT);

  logic [INFLIGHT_W-1:0] inflight_q;
  logic [STALL_W-1:0]    stall_q;
  logic                  error_q;
  logic                  busy_rd, busy_rs, busy_rt;
  logic                  hazard, room, fire, retire, stalled;

  sb_pending_file #(.NUM_REGS(NUM_REGS)) u_pending (
    .clk     (clk),
    .reset   (reset),
    .set_en  (fire && iss_rd_we),
    .set_idx (iss_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .look_a  (iss_rd),
    .look_b  (iss_rs),
    .look_c  (iss_rt),
    .busy_a  (busy_rd),
    .busy_b  (busy_rs),
    .busy_c  (busy_rt)
  );

  assign hazard  = (iss_rs_used && busy_rs) || (iss_rt_used && busy_rt) || (iss_rd_we && busy_rd);
  assign room    = (inflight_q < MAX_CNT) || wb_valid;
  assign iss_ready = !hazard && room;
  assign fire    = iss_valid && iss_ready;
  // A commit with nothing in flight is a protocol error and must not underflow.
  assign retire  = wb_valid && (inflight_q != '0);
  assign stalled = iss_valid && !iss_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      stall_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      case ({fire, retire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      if (stalled && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (wb_valid && (inflight_q == '0)) error_q <= 1'b1;
    end
  end

  assign inflight  = inflight_q;
  assign stall_cnt = stall_q;
  assign sb_error  = error_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed scenarios plus randomized issue/commit traffic, checked against a
// register-set/queue model of outstanding instructions.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0, iss_rs = '0, iss_rt = '0;
  logic        iss_rd_we = 1'b0, iss_rs_used = 1'b0, iss_rt_used = 1'b0;
  logic        iss_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [2:0]  inflight;
  logic [31:0] stall_cnt;
  logic        sb_error;

  issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_rd_we(iss_rd_we), .iss_rs_used(iss_rs_used), .iss_rt_used(iss_rt_used),
    .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .inflight(inflight), .stall_cnt(stall_cnt), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: set of registers with an outstanding write, count of outstanding
  // instructions, and a list of them (-1 marks a non-writing instruction).
  bit              m_pend[32];
  int              m_cnt;
  longint unsigned m_stall;
  bit              m_err;
  int              q_out[$];

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt = 0; m_stall = 0; m_err = 1'b0;
    q_out.delete();
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit v, input int rd, input int rs, input int rt,
                      input bit we, input bit ru, input bit tu,
                      input bit wb, input int wrd);
    bit busy_rs, busy_rt, busy_rd, exp_rdy, fire;
    int idx;
    iss_valid = v; iss_rd = 5'(rd); iss_rs = 5'(rs); iss_rt = 5'(rt);
    iss_rd_we = we; iss_rs_used = ru; iss_rt_used = tu;
    wb_valid = wb; wb_rd = 5'(wrd);
    #1;
    busy_rs = m_pend[rs] && !(wb && wrd == rs);
    busy_rt = m_pend[rt] && !(wb && wrd == rt);
    busy_rd = m_pend[rd] && !(wb && wrd == rd);
    exp_rdy = !((ru && busy_rs) || (tu && busy_rt) || (we && busy_rd)) && (m_cnt < 4 || wb);
    chk("iss_ready", iss_ready, exp_rdy);
    fire = v && exp_rdy;
    @(posedge clk); #1;
    if (v && !exp_rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (wb) begin
      if (m_cnt == 0) m_err = 1'b1;
      else begin
        m_cnt--;
        idx = -1;
        for (int i = 0; i < q_out.size(); i++)
          if (idx < 0 && q_out[i] == (m_pend[wrd] ? wrd : -1)) idx = i;
        if (idx >= 0) q_out.delete(idx);
      end
      m_pend[wrd] = 1'b0;
    end
    if (fire) begin
      m_cnt++;
      if (we) m_pend[rd] = 1'b1;
      q_out.push_back(we ? rd : -1);
    end
    chk("inflight", inflight, m_cnt);
    chk("stall_cnt", stall_cnt, 32'(m_stall));
    chk("sb_error", sb_error, m_err);
    @(negedge clk);
  endtask

  task automatic idle(input bit wb, input int wrd);
    step(0, 0, 0, 0, 0, 0, 0, wb, wrd);
  endtask

  task automatic do_reset();
    iss_valid = 1'b1; iss_rd = 5'd3; iss_rd_we = 1'b1;
    wb_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_error", sb_error, 0);
    chk("rst_ready", iss_ready, 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int rd, rs, rt, wrd, k;
    bit v, we, ru, tu, wb;
    model_reset();
    @(negedge clk);
    do_reset();

    // mov r5 then add r1,r5,r6 waiting on commit of r5 four cycles later
    step(1, 5, 0, 0, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 5, 6, 1, 1, 1, 0, 0);
    step(1, 1, 5, 6, 1, 1, 1, 1, 5);
    chk("raw_stall_cnt", stall_cnt, 3);
    chk("raw_inflight", inflight, 1);
    idle(1, 1);

    // Four independent writes fill the window; the fifth waits for a commit
    do_reset();
    for (int r = 5; r <= 8; r++) step(1, r, 0, 0, 1, 0, 0, 0, 0);
    step(1, 9, 0, 0, 1, 0, 0, 0, 0);
    chk("full_inflight", inflight, 4);
    chk("full_stall", stall_cnt, 1);
    step(1, 9, 0, 0, 1, 0, 0, 1, 5);
    chk("full_fire_inflight", inflight, 4);

    // Commit and reissue of r7 in the same cycle keeps r7 pending
    do_reset();
    step(1, 7, 0, 0, 1, 0, 0, 0, 0);
    step(1, 7, 0, 0, 1, 0, 0, 1, 7);
    chk("setwins_inflight", inflight, 1);
    step(1, 2, 7, 0, 1, 1, 0, 0, 0);
    chk("setwins_stall", stall_cnt, 1);

    // Commit with nothing in flight
    do_reset();
    idle(1, 0);
    chk("err_set", sb_error, 1);
    repeat (10) idle(0, 0);
    chk("err_sticky", sb_error, 1);
    chk("err_inflight", inflight, 0);

    // Async reset in the middle of a stall with three in flight
    do_reset();
    for (int r = 1; r <= 3; r++) step(1, r, 0, 0, 1, 0, 0, 0, 0);
    step(1, 4, 1, 0, 1, 1, 0, 0, 0);
    chk("pre_rst_inflight", inflight, 3);
    iss_valid = 1'b1; iss_rs = 5'd1; iss_rs_used = 1'b1; iss_rd_we = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_inflight", inflight, 0);
    chk("async_stall", stall_cnt, 0);
    chk("async_ready", iss_ready, 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // NOP counts toward inflight but reserves nothing
    step(1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("nop_inflight", inflight, 1);
    step(1, 4, 3, 3, 1, 1, 1, 0, 0);
    chk("nop_no_stall", stall_cnt, 0);
    idle(1, 31);
    chk("nop_retire_err", sb_error, 0);
    idle(1, 4);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      v  = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 7);
      rs = $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      we = $urandom_range(0, 3) != 0;
      ru = $urandom_range(0, 1);
      tu = $urandom_range(0, 1);
      wb = (q_out.size() > 0) && ($urandom_range(0, 2) == 0);
      wrd = 0;
      if (wb) begin
        k = $urandom_range(0, q_out.size() - 1);
        if (q_out[k] >= 0) wrd = q_out[k];
        else begin
          wrd = $urandom_range(0, 31);
          while (m_pend[wrd]) wrd = (wrd + 1) % 32;
        end
      end
      step(v, rd, rs, rt, we, ru, tu, wb, wrd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
